// File: rtl/deflect_port_alloc_pkg.sv
// Shared definitions for the deflection router port allocator: coordinate/port macros,
// flit field offsets, port indices, slot/rank sizes and the per-flit port pick rule.
// Latency: n/a (definitions only). Backpressure: n/a.
`ifndef WIDTH_COORDINATE
`define WIDTH_COORDINATE 3
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef SIZE_NETWORK
`define SIZE_NETWORK 8
`endif

// Flit layout from MSB: age, dstX, dstY, data. Offsets are given as LSB positions
// relative to the payload width dw.
`define FLIT_DATA_LSB 0
`define FLIT_DSTY_LSB(dw) (dw)
`define FLIT_DSTX_LSB(dw) ((dw) + `WIDTH_COORDINATE)
`define FLIT_AGE_LSB(dw) ((dw) + 2 * `WIDTH_COORDINATE)

package deflect_port_alloc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AGE_W_DEF  = 8;
  localparam int COORD_W    = `WIDTH_COORDINATE;
  localparam int PORT_CNT   = `NUM_PORT;
  localparam int NUM_NET    = 4;
  // Four network slots plus one injection slot.
  localparam int NUM_SLOT   = 5;
  localparam int RANK_W     = 3;

  localparam logic [2:0] PORT_W = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  typedef struct packed {
    logic [2:0] port;
    logic       deflected;
  } grant_t;

  // One flit's grant against the ports still free: eject if local is productive and
  // free, else lowest free productive network port, else lowest free network port.
  function automatic grant_t pickPort(input logic [PORT_CNT-1:0] prod,
                                      input logic [PORT_CNT-1:0] free);
    grant_t g;
    logic   found;
    g.port      = PORT_W;
    g.deflected = 1'b0;
    found       = 1'b0;
    if (prod[PORT_L] && free[PORT_L]) begin
      g.port = PORT_L;
      found  = 1'b1;
    end
    for (int p = 0; p < NUM_NET; p++) begin
      if (!found && prod[p] && free[p]) begin
        g.port = 3'(p);
        found  = 1'b1;
      end
    end
    for (int p = 0; p < NUM_NET; p++) begin
      if (!found && free[p]) begin
        g.port      = 3'(p);
        g.deflected = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/deflect_port_alloc_rank.sv
// Per-slot priority rank: number of valid slots that beat this one (older wins, ties to lower index).
// Latency: combinational.
// Backpressure: none.
module alloc_rank
  import deflect_port_alloc_pkg::*;
#(
  parameter int AGE_W = AGE_W_DEF
) (
  input  logic [NUM_SLOT-1:0]        valid,
  input  logic [NUM_SLOT*AGE_W-1:0]  age,
  output logic [NUM_SLOT*RANK_W-1:0] rank
);

  logic [RANK_W-1:0] cnt;
  logic [AGE_W-1:0]  ageI;
  logic [AGE_W-1:0]  ageJ;

  // Count competitors ahead of each slot; the injection slot has the highest index so it loses every tie.
  always_comb begin
    rank = '0;
    cnt  = '0;
    ageI = '0;
    ageJ = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      cnt  = '0;
      ageI = age[i*AGE_W +: AGE_W];
      for (int j = 0; j < NUM_SLOT; j++) begin
        ageJ = age[j*AGE_W +: AGE_W];
        if (j != i && valid[j]) begin
          if ((ageJ > ageI) || ((ageJ == ageI) && (j < i))) begin
            cnt = cnt + RANK_W'(1);
          end
        end
      end
      rank[i*RANK_W +: RANK_W] = cnt;
    end
  end

endmodule

// File: rtl/deflect_port_alloc.sv
// Two-stage oldest-first port allocator (optional deflection counter under ALLOC_DEFLECT_CNT_EN).
// Latency: 2 cycles from input capture edge to registered out_*/ej_*.
// Backpressure: none on network links; inj_ready drops only when all four links carry a flit.
module deflect_port_alloc
  import deflect_port_alloc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AGE_W  = AGE_W_DEF,
  parameter int FLIT_W = DATA_W + 2 * `WIDTH_COORDINATE + AGE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  in_valid,
  input  logic [4*FLIT_W-1:0]         in_flit,
  input  logic [4*`NUM_PORT-1:0]      in_prod,
  input  logic                        inj_valid,
  input  logic [FLIT_W-1:0]           inj_flit,
  input  logic [`NUM_PORT-1:0]        inj_prod,
  output logic                        inj_ready,
  output logic [3:0]                  out_valid,
  output logic [4*FLIT_W-1:0]         out_flit,
  output logic                        ej_valid,
  output logic [FLIT_W-1:0]           ej_flit
`ifdef ALLOC_DEFLECT_CNT_EN
  ,
  output logic [15:0]                 deflect_cnt
`endif
);

  localparam int AGE_LSB = `FLIT_AGE_LSB(DATA_W);

  // Stage A registers.
  logic [NUM_SLOT-1:0]                aValid;
  logic [NUM_SLOT-1:0][FLIT_W-1:0]    aFlit;
  logic [NUM_SLOT-1:0][PORT_CNT-1:0]  aProd;

  logic                               injTake;
  logic [FLIT_W-1:0]                  injFlitNew;

  // Stage B combinational results and output registers.
  logic [NUM_SLOT*AGE_W-1:0]          slotAge;
  logic [NUM_SLOT*RANK_W-1:0]         slotRank;
  logic [PORT_CNT-1:0]                freeMask;
  grant_t                             grant;
  logic [3:0]                         nxtOutValid;
  logic [3:0][FLIT_W-1:0]             nxtOutFlit;
  logic                               nxtEjValid;
  logic [FLIT_W-1:0]                  nxtEjFlit;
  logic [3:0]                         outValidQ;
  logic [3:0][FLIT_W-1:0]             outFlitQ;
  logic                               ejValidQ;
  logic [FLIT_W-1:0]                  ejFlitQ;
`ifdef ALLOC_DEFLECT_CNT_EN
  logic [2:0]                         deflNum;
  logic [15:0]                        deflCntQ;
  logic [16:0]                        cntSum;
`endif

  // Network age saturates so the oldest flits keep their priority instead of wrapping to youngest.
  function automatic logic [FLIT_W-1:0] bumpAge(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] r;
    logic [AGE_W-1:0]  a;
    r = f;
    a = f[AGE_LSB +: AGE_W];
    if (a != {AGE_W{1'b1}}) begin
      a = a + AGE_W'(1);
    end
    r[AGE_LSB +: AGE_W] = a;
    return r;
  endfunction

  // With at most three network flits there is always a spare port, so every flit in stage A gets one.
  assign inj_ready = ~(&in_valid);
  assign injTake   = inj_valid & inj_ready;

  // Injected flits start life at age zero whatever the source wrote into the field.
  always_comb begin
    injFlitNew = inj_flit;
    injFlitNew[AGE_LSB +: AGE_W] = '0;
  end

  // Stage A valid capture; reset drops anything arriving, including an accepted injection.
  always_ff @(posedge clk) begin
    if (reset) begin
      aValid <= '0;
    end else begin
      aValid <= {injTake, in_valid};
    end
  end

  // Stage A payload capture: network slots every cycle, injection slot only when accepted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NET; i++) begin
      aFlit[i] <= in_flit[i*FLIT_W +: FLIT_W];
      aProd[i] <= in_prod[i*PORT_CNT +: PORT_CNT];
    end
    if (injTake) begin
      aFlit[NUM_SLOT-1] <= injFlitNew;
      aProd[NUM_SLOT-1] <= inj_prod;
    end
  end

  // Gather slot ages for the ranking network.
  always_comb begin
    slotAge = '0;
    for (int s = 0; s < NUM_SLOT; s++) begin
      slotAge[s*AGE_W +: AGE_W] = aFlit[s][AGE_LSB +: AGE_W];
    end
  end

  alloc_rank #(
    .AGE_W (AGE_W)
  ) uRank (
    .valid (aValid),
    .age   (slotAge),
    .rank  (slotRank)
  );

  // Grant slots in rank order against a shrinking free-port mask; unused outputs keep their old flit bits.
  always_comb begin
    freeMask    = '1;
    grant       = '0;
    nxtOutValid = '0;
    nxtOutFlit  = outFlitQ;
    nxtEjValid  = 1'b0;
    nxtEjFlit   = ejFlitQ;
`ifdef ALLOC_DEFLECT_CNT_EN
    deflNum     = '0;
`endif
    for (int r = 0; r < NUM_SLOT; r++) begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        if (aValid[s] && (slotRank[s*RANK_W +: RANK_W] == RANK_W'(r))) begin
          grant = pickPort(aProd[s], freeMask);
          freeMask[grant.port] = 1'b0;
          if (grant.port == PORT_L) begin
            nxtEjValid = 1'b1;
            nxtEjFlit  = aFlit[s];
          end else begin
            nxtOutValid[grant.port[1:0]] = 1'b1;
            nxtOutFlit[grant.port[1:0]]  = bumpAge(aFlit[s]);
          end
`ifdef ALLOC_DEFLECT_CNT_EN
          deflNum = deflNum + 3'(grant.deflected);
`endif
        end
      end
    end
  end

  // Stage B valid registers; reset discards the allocation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValidQ <= '0;
      ejValidQ  <= 1'b0;
    end else begin
      outValidQ <= nxtOutValid;
      ejValidQ  <= nxtEjValid;
    end
  end

  // Stage B payload registers; the comb defaults make idle ports hold their value.
  always_ff @(posedge clk) begin
    outFlitQ <= nxtOutFlit;
    ejFlitQ  <= nxtEjFlit;
  end

  assign out_valid = outValidQ;
  assign out_flit  = outFlitQ;
  assign ej_valid  = ejValidQ;
  assign ej_flit   = ejFlitQ;

`ifdef ALLOC_DEFLECT_CNT_EN
  assign cntSum = {1'b0, deflCntQ} + 17'(deflNum);

  // Saturating tally of deflections, advanced alongside every registered allocation.
  always_ff @(posedge clk) begin
    if (reset) begin
      deflCntQ <= '0;
    end else begin
      deflCntQ <= cntSum[16] ? 16'hFFFF : cntSum[15:0];
    end
  end

  assign deflect_cnt = deflCntQ;
`endif

endmodule

// File: tb/tb_deflect_port_alloc.sv
// Scoreboarded bench for deflect_port_alloc: directed cases then random flit sets vs a reference model.
// Latency: expectations are due two cycles after the driving cycle.
// Backpressure: injections are offered freely; acceptance follows inj_ready.
module tb_deflect_port_alloc;
  import deflect_port_alloc_pkg::*;

  localparam int DATA_W  = 32;
  localparam int AGE_W   = 8;
  localparam int CW      = COORD_W;
  localparam int FLIT_W  = DATA_W + 2 * CW + AGE_W;
  localparam int NP      = PORT_CNT;
  localparam int AGE_LSB = DATA_W + 2 * CW;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic                  clk;
  logic                  reset;
  logic [3:0]            in_valid;
  logic [4*FLIT_W-1:0]   in_flit;
  logic [4*NP-1:0]       in_prod;
  logic                  inj_valid;
  logic [FLIT_W-1:0]     inj_flit;
  logic [NP-1:0]         inj_prod;
  logic                  inj_ready;
  logic [3:0]            out_valid;
  logic [4*FLIT_W-1:0]   out_flit;
  logic                  ej_valid;
  logic [FLIT_W-1:0]     ej_flit;
`ifdef ALLOC_DEFLECT_CNT_EN
  logic [15:0]           deflect_cnt;
`endif

  typedef struct {
    int                     due;
    logic [3:0]             ov;
    logic                   ev;
    logic [3:0][FLIT_W-1:0] of;
    logic [FLIT_W-1:0]      ef;
    int                     ndefl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   expCnt = 0;
  bit   pendRst = 1'b0;

  deflect_port_alloc #(
    .DATA_W (DATA_W),
    .AGE_W  (AGE_W),
    .FLIT_W (FLIT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_prod    (in_prod),
    .inj_valid  (inj_valid),
    .inj_flit   (inj_flit),
    .inj_prod   (inj_prod),
    .inj_ready  (inj_ready),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .ej_valid   (ej_valid),
    .ej_flit    (ej_flit)
`ifdef ALLOC_DEFLECT_CNT_EN
    ,
    .deflect_cnt(deflect_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mkFlit(input int age);
    logic [FLIT_W-1:0] r;
    r = '0;
    r[DATA_W-1:0] = $urandom;
    r[DATA_W +: 2*CW] = (2*CW)'($urandom);
    r[AGE_LSB +: AGE_W] = AGE_W'(age);
    return r;
  endfunction

  function automatic int randAge();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 3);
      1:       return $urandom_range(250, 255);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  // Oldest first (ties to lower slot), each flit greedily takes a port from what is left.
  function automatic exp_t refModel(input logic [4:0] v, input logic [4:0][FLIT_W-1:0] f,
                                    input logic [4:0][NP-1:0] p, input int due);
    exp_t e;
    bit   done[5];
    bit   free[5];
    int   ages[5];
    e.due = due; e.ov = '0; e.ev = 1'b0; e.of = '0; e.ef = '0; e.ndefl = 0;
    for (int s = 0; s < 5; s++) begin
      ages[s] = int'(f[s][AGE_LSB +: AGE_W]);
      done[s] = 1'b0;
      free[s] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      int best;
      int port;
      int age1;
      best = -1;
      for (int s = 0; s < 5; s++)
        if (v[s] && !done[s] && (best < 0 || ages[s] > ages[best])) best = s;
      if (best >= 0) begin
        done[best] = 1'b1;
        port = -1;
        if (p[best][4] && free[4]) port = 4;
        for (int q = 0; q < 4; q++) if (port < 0 && p[best][q] && free[q]) port = q;
        for (int q = 0; q < 4; q++) if (port < 0 && free[q]) begin port = q; e.ndefl++; end
        free[port] = 1'b0;
        if (port == 4) begin
          e.ev = 1'b1;
          e.ef = f[best];
        end else begin
          age1 = (ages[best] + 1 > AGE_MAX) ? AGE_MAX : ages[best] + 1;
          e.ov[port] = 1'b1;
          e.of[port] = f[best];
          e.of[port][AGE_LSB +: AGE_W] = AGE_W'(age1);
        end
      end
    end
    return e;
  endfunction

  // Drive one cycle of stimulus (called #1 after a rising edge) and post its expectation.
  task automatic drive(input logic [3:0] v, input logic [3:0][FLIT_W-1:0] f,
                       input logic [3:0][NP-1:0] p, input logic iv,
                       input logic [FLIT_W-1:0] jf, input logic [NP-1:0] jp, input logic rst);
    logic                   acc;
    logic [FLIT_W-1:0]      jz;
    exp_t                   e;
    in_valid = v; in_flit = f; in_prod = p;
    inj_valid = iv; inj_flit = jf; inj_prod = jp; reset = rst;
    #1;
    check("inj_ready", inj_ready, (v != 4'b1111));
    acc = iv && (v != 4'b1111);
    jz = jf;
    jz[AGE_LSB +: AGE_W] = '0;
    if (rst) begin
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
    end else if ((|v) || acc) begin
      e = refModel({acc, v}, {jz, f}, {jp, p}, cyc + 2);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: pops an expectation whenever one falls due, and flags any output nobody expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pendRst) begin
        expCnt  = 0;
        pendRst = 1'b0;
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("out_valid", out_valid, e.ov);
        check("ej_valid", ej_valid, e.ev);
        for (int q = 0; q < 4; q++)
          if (e.ov[q]) check($sformatf("out_flit[%0d]", q), 64'(out_flit[q*FLIT_W +: FLIT_W]), 64'(e.of[q]));
        if (e.ev) check("ej_flit", 64'(ej_flit), 64'(e.ef));
        expCnt = (expCnt + e.ndefl > 65535) ? 65535 : expCnt + e.ndefl;
      end else if ((|out_valid) || ej_valid) begin
        check("unexpected output", {out_valid, ej_valid}, 5'b0);
      end
`ifdef ALLOC_DEFLECT_CNT_EN
      check("deflect_cnt", deflect_cnt, expCnt);
`endif
      if (reset) pendRst = 1'b1;
    end
  end

  initial begin
    logic [3:0][FLIT_W-1:0] f;
    logic [3:0][NP-1:0]     p;
    logic [3:0]             v;
    reset = 1'b1; in_valid = '0; in_flit = '0; in_prod = '0;
    inj_valid = 1'b0; inj_flit = '0; inj_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 4'b0);
    check("reset ej_valid", ej_valid, 1'b0);
`ifdef ALLOC_DEFLECT_CNT_EN
    check("reset deflect_cnt", deflect_cnt, 16'h0);
`endif
    reset = 1'b0;

    // Single flit W age 3 productive N.
    f = '0; p = '0; f[0] = mkFlit(3); p[0] = 5'b01000;
    drive(4'b0001, f, p, 1'b0, '0, '0, 1'b0);
    idle(2);
    // Contention E age 9 vs S age 5 on port E.
    f = '0; p = '0; f[1] = mkFlit(9); f[2] = mkFlit(5); p[1] = 5'b00010; p[2] = 5'b00010;
    drive(4'b0110, f, p, 1'b0, '0, '0, 1'b0);
    // Equal age 7 on W and N, both want local.
    f = '0; p = '0; f[0] = mkFlit(7); f[3] = mkFlit(7); p[0] = 5'b10000; p[3] = 5'b10000;
    drive(4'b1001, f, p, 1'b0, '0, '0, 1'b0);
    // Injection gating: full load refuses, three links accept.
    for (int i = 0; i < 4; i++) begin f[i] = mkFlit(randAge()); p[i] = 5'(1 << i); end
    drive(4'b1111, f, p, 1'b1, mkFlit(77), 5'b00010, 1'b0);
    drive(4'b0111, f, p, 1'b1, mkFlit(77), 5'b01000, 1'b0);
    // Saturation: 255 beats 254, and a tie at 255 goes to the lower slot.
    f = '0; p = '0; f[0] = mkFlit(254); f[1] = mkFlit(255); p[0] = 5'b00100; p[1] = 5'b00100;
    drive(4'b0011, f, p, 1'b0, '0, '0, 1'b0);
    f[0] = mkFlit(255); f[2] = mkFlit(255); p[2] = 5'b00100;
    drive(4'b0111, f, p, 1'b1, mkFlit(255), 5'b00100, 1'b0);
    idle(2);
    // Reset while both stages hold flits.
    for (int i = 0; i < 4; i++) begin f[i] = mkFlit(randAge()); p[i] = 5'($urandom); end
    drive(4'b1011, f, p, 1'b1, mkFlit(1), 5'b00001, 1'b0);
    drive(4'b0101, f, p, 1'b1, mkFlit(1), 5'b00001, 1'b0);
    drive(4'b1111, f, p, 1'b1, mkFlit(1), 5'b00001, 1'b1);
    idle(4);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      v = 4'($urandom);
      for (int i = 0; i < 4; i++) begin f[i] = mkFlit(randAge()); p[i] = 5'($urandom); end
      drive(v, f, p, 1'($urandom), mkFlit(randAge()), 5'($urandom) & 5'b01111,
            ($urandom_range(0, 199) == 0));
    end
    idle(4);
    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/deflect_port_alloc.md
# deflect_port_alloc

Two-stage oldest-first port allocator for the bufferless deflection router. It sits directly downstream of the per-port lookahead route computation. It latches the flits arriving on the four network links, together with their precomputed productive vectors and an optional local injection, and assigns every flit exactly one output port. Each flit takes a free productive port if one exists; otherwise it is deflected to a free unproductive port.

## Interface
Parameters:
- DATA_W, 32, payload width.
- AGE_W, 8, age field width; age saturates at 2^AGE_W-1.
- FLIT_W, DATA_W+2*`WIDTH_COORDINATE+AGE_W. Flit layout from MSB: age, dstX, dstY, data.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  4  per network input; index 0 W, 1 E, 2 S, 3 N.
- in_flit  in  4*FLIT_W  packed flits, port i at bits [i*FLIT_W +: FLIT_W].
- in_prod  in  4*`NUM_PORT  productive vectors; bit0 W, 1 E, 2 S, 3 N, 4 local.
- inj_valid  in  1  injection request.
- inj_flit  in  FLIT_W  injected flit, age field ignored and forced to 0.
- inj_prod  in  `NUM_PORT  injected productive vector; bit4 must be 0.
- inj_ready  out  1  injection accepted this cycle when inj_valid & inj_ready.
- out_valid  out  4  network outputs W/E/S/N, registered.
- out_flit  out  4*FLIT_W  output flits, age already incremented.
- ej_valid  out  1  ejection to local port, registered.
- ej_flit  out  FLIT_W  ejected flit.
- deflect_cnt  out  16  present only with ALLOC_DEFLECT_CNT_EN.

## Operation
- Stage A (capture): registers a_valid[4:0], a_flit, a_prod. Slots 0–3 take in_* unconditionally each cycle. Slot 4 takes the injection when inj_valid & inj_ready.
- inj_ready = popcount(in_valid) < 4. It is combinational from in_valid and guarantees at most 4 flits in stage A, so every flit always gets a port.
- Stage B (allocate): combinational over stage A registers; results registered into out_*/ej_*.
- Priority rank: higher age first. Ties go to the lower slot index. Slot 4 (injection) always loses ties.
- Flits are granted in rank order against a free-port mask (W,E,S,N,local), initially all free:
  - If the flit's productive set contains local and local is free, the flit ejects.
  - Else it takes the lowest-indexed free port in prod[3:0].
  - Else (deflection) it takes the lowest-indexed free network port. A flit whose only productive bit is local, but finds local already taken, deflects the same way.
- Age update: output age = min(age+1, 2^AGE_W-1) for network outputs. Ejected flits leave with unmodified age.
- Invalid slots consume no port. Unused outputs drive valid=0, and their flit bits hold previous values.
- An inj_prod with bit4 set is a protocol violation. The block still produces a legal assignment; no check is made.

## Timing
- Latency 2 cycles: flit presented at edge n appears on out_*/ej_* after edge n+2. Throughput one flit set per cycle, no backpressure on network links.
- Reset: a_valid, out_valid, ej_valid = 0 at the first edge with reset high. deflect_cnt = 0.
- Reset mid-operation: in-flight flits in both stages are dropped. inj_ready is still computed combinationally during reset, but captured injections are discarded.
- Simultaneous full load (4 network flits valid): inj_ready=0. All four take W/E/S/N or local, with at most one ejecting.
- Age at max: stays at max on output. The tie rule still applies.

## Configuration
- ALLOC_DEFLECT_CNT_EN defined: the deflect_cnt port exists.
  - Increments on each registered stage-B result by the number of flits that were deflected that cycle.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and its logic are absent. Allocation behaviour is identical.

## Structure
- Shared package (alongside `WIDTH_COORDINATE, `NUM_PORT, `SIZE_NETWORK):
  - Port index constants PORT_W=0, PORT_E=1, PORT_S=2, PORT_N=3, PORT_L=4.
  - Flit field offset macros.
  - AGE_W default.
- One sub-module: alloc_rank. Purely combinational; produces per-slot rank from ages, valids and the tie rule. It is instantiated once inside stage B.

## Test plan
- Single flit, age 3, in W with prod=5'b01000 -> after 2 cycles out_valid=4'b1000, N flit age 4; ej_valid=0.
- Contention: E age 9 and S age 5, both prod=5'b00010 -> E flit on port E age 10; S flit deflected to W age 6; deflect_cnt +1.
- Equal age 7 on W and N, both prod=5'b10000 -> W ejects; N deflected to W output; out_valid=4'b0001, ej_valid=1.
- Injection gating: in_valid=4'b1111 with inj_valid=1 -> inj_ready=0, nothing captured in slot 4. Next cycle in_valid=4'b0111 -> inj_ready=1; injected flit leaves with age 1.
- Saturation: flit age 255 (AGE_W=8) -> output age 255. It wins over an age-254 flit for the same productive port.
- Reset asserted for one cycle while stages A and B hold valid flits -> the following cycle out_valid=0 and ej_valid=0, and no flit is emitted later.
